uart_transmitter: RTL and testbench

- Serialises bytes onto the UART tx line; the transmit-side counterpart of the UART receive path.
- Frame format is runtime-configurable with the same encoding as the receiver: 5–8 data bits, optional parity (space/mark/even/odd), 1 or 2 stop bits, and a programmable bit period.
- Has a one-entry holding register so back-to-back frames go out with no idle gap.
- Supports an explicit break request.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_transmitter_if.sv | 21 ++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_transmitter.sv | 181 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, tx state encoding,
// frame constants and the parity helper used by the transmit path.
package uart_pkg;

   localparam logic [1:0] PARITY_SPACE = 2'b00;
   localparam logic [1:0] PARITY_ODD   = 2'b01;
   localparam logic [1:0] PARITY_EVEN  = 2'b10;
   localparam logic [1:0] PARITY_MARK  = 2'b11;

   localparam int DATA_BITS_BASE = 5;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP1,
      TX_STOP2,
      TX_BREAK
   } tx_state_e;

   // Parity over the low (bits+5) data bits only.
   function automatic logic parity_bit(
      input logic [7:0] data,
      input logic [1:0] bits,
      input logic [1:0] mode
   );
      logic x;
      x = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(bits) + DATA_BITS_BASE) x = x ^ data[i];
      end
      unique case (mode)
         PARITY_EVEN:  parity_bit = x;
         PARITY_ODD:   parity_bit = ~x;
         PARITY_MARK:  parity_bit = 1'b1;
         PARITY_SPACE: parity_bit = 1'b0;
         default:      parity_bit = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between a data source and the UART transmitter.
// Ports: dataIn/dataValid from master, ready from slave.
interface uart_transmitter_if;

   logic [7:0] dataIn;
   logic       dataValid;
   logic       ready;

   modport master (
      output dataIn,
      output dataValid,
      input  ready
   );

   modport slave (
      input  dataIn,
      input  dataValid,
      output ready
   );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Ports: clk, rst (async low), load, value, done.
module uart_bit_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             done
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter with one-entry holding register and break support.
// Ports: clk, rst (async low), frame config, host handshake, breakReq, busy, tx.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLOCK_DIVISOR_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [1:0]                     dataBits,
   input  logic                           hasParity,
   input  logic [1:0]                     parityMode,
   input  logic                           extraStopBit,
   input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
   uart_transmitter_if.slave              host,
   input  logic                           breakReq,
   output logic                           busy,
   output logic                           tx
);

   localparam int DW = CLOCK_DIVISOR_WIDTH;

   tx_state_e state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q;
   logic [7:0] hold_data;
   logic       hold_full;
   logic [1:0] dbits_q;
   logic       par_en_q;
   logic [1:0] par_mode_q;
   logic       two_stop_q;
   logic [DW-1:0] div_q;

   logic          take;
   logic          brk_load;
   logic          eof;
   logic          load;
   logic          tmr_load;
   logic          tmr_done;
   logic [DW-1:0] tmr_val;
   logic [2:0]    last_idx;
   logic          tx_d;

   assign host.ready = ~hold_full;
   assign load       = host.dataValid & ~hold_full;
   assign busy       = (state_q != TX_IDLE) | hold_full;
   assign last_idx   = {1'b0, dbits_q} + 3'd4;

   // Config is sampled on frame/break entry, so the timer
   // must take the live divisor on that same edge.
   assign tmr_val = (take | brk_load) ? clockDivisor : div_q;

   uart_bit_timer #(
      .WIDTH(DW)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_val),
      .done  (tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      take     = 1'b0;
      brk_load = 1'b0;
      eof      = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            if (breakReq) begin
               state_d  = TX_BREAK;
               brk_load = 1'b1;
            end else if (hold_full) begin
               state_d = TX_START;
               take    = 1'b1;
            end
         end
         TX_START: begin
            if (tmr_done) begin
               state_d = TX_DATA;
               idx_d   = 3'd0;
            end
         end
         TX_DATA: begin
            if (tmr_done) begin
               if (idx_q == last_idx) begin
                  state_d = par_en_q ? TX_PARITY : TX_STOP1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         TX_PARITY: begin
            if (tmr_done) state_d = TX_STOP1;
         end
         TX_STOP1: begin
            if (tmr_done) begin
               if (two_stop_q) state_d = TX_STOP2;
               else            eof = 1'b1;
            end
         end
         TX_STOP2: begin
            if (tmr_done) eof = 1'b1;
         end
         TX_BREAK: begin
            if (tmr_done && !breakReq) state_d = TX_STOP1;
         end
         default: state_d = TX_IDLE;
      endcase

      // Break outranks a buffered byte at frame end.
      if (eof) begin
         if (breakReq) begin
            state_d  = TX_BREAK;
            brk_load = 1'b1;
         end else if (hold_full) begin
            state_d = TX_START;
            take    = 1'b1;
         end else begin
            state_d = TX_IDLE;
         end
      end

      tmr_load = (state_d != state_q) | (idx_d != idx_q);

      tx_d = 1'b1;
      unique case (state_d)
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = shift_q[idx_d];
         TX_PARITY: tx_d = parity_bit(shift_q, dbits_q, par_mode_q);
         TX_BREAK:  tx_d = 1'b0;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= TX_IDLE;
         idx_q   <= 3'd0;
         tx      <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tx      <= tx_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_full <= 1'b0;
         hold_data <= 8'h00;
      end else begin
         hold_full <= (hold_full & ~take) | load;
         if (load) hold_data <= host.dataIn;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q    <= 8'h00;
         dbits_q    <= 2'd3;
         par_en_q   <= 1'b0;
         par_mode_q <= PARITY_SPACE;
         two_stop_q <= 1'b0;
         div_q      <= '0;
      end else if (take) begin
         shift_q    <= hold_data;
         dbits_q    <= dataBits;
         par_en_q   <= hasParity;
         par_mode_q <= parityMode;
         two_stop_q <= extraStopBit;
         div_q      <= clockDivisor;
      end else if (brk_load) begin
         // The stop after a break is always a single bit.
         two_stop_q <= 1'b0;
         div_q      <= clockDivisor;
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter.
// Drives bytes/config, compares tx per cycle against a bit-list model.
module tb_uart_transmitter;

   logic        clk;
   logic        rst;
   logic [1:0]  dataBits;
   logic        hasParity;
   logic [1:0]  parityMode;
   logic        extraStopBit;
   logic [15:0] clockDivisor;
   logic        breakReq;
   logic        busy;
   logic        tx;

   uart_transmitter_if bus ();

   uart_transmitter #(
      .CLOCK_DIVISOR_WIDTH(16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .dataBits     (dataBits),
      .hasParity    (hasParity),
      .parityMode   (parityMode),
      .extraStopBit (extraStopBit),
      .clockDivisor (clockDivisor),
      .host         (bus),
      .breakReq     (breakReq),
      .busy         (busy),
      .tx           (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit exp_q[$];

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Expected line levels of one frame, one entry per bit.
   function automatic void build(input logic [7:0] d);
      int n;
      int ones;
      n = int'(dataBits) + 5;
      ones = 0;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (hasParity) begin
         case (parityMode)
            2'b10:   exp_q.push_back(bit'(ones % 2));
            2'b01:   exp_q.push_back(bit'(1 - ones % 2));
            2'b11:   exp_q.push_back(1'b1);
            default: exp_q.push_back(1'b0);
         endcase
      end
      exp_q.push_back(1'b1);
      if (extraStopBit) exp_q.push_back(1'b1);
   endfunction

   // First sample is taken at the current negedge (the start bit).
   task automatic check_frame(input string tag, input logic [7:0] d);
      int good;
      int len;
      build(d);
      len = int'(clockDivisor) + 1;
      for (int i = 0; i < exp_q.size(); i++) begin
         good = 0;
         for (int c = 0; c < len; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            if (tx === exp_q[i]) good++;
         end
         chk($sformatf("%s_bit%0d", tag, i), good, len);
      end
   endtask

   task automatic put_byte(input logic [7:0] d);
      int n;
      bus.dataIn    = d;
      bus.dataValid = 1'b1;
      n = 0;
      while (bus.ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("put_timeout", 0, 1);
      @(negedge clk);
      bus.dataValid = 1'b0;
   endtask

   task automatic wait_start(input string tag, input int exp_lat);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx !== 1'b0 && n < 2000);
      chk(tag, n, exp_lat);
   endtask

   task automatic set_cfg(
      input logic [1:0] b, input logic p, input logic [1:0] m,
      input logic s, input logic [15:0] dv
   );
      dataBits     = b;
      hasParity    = p;
      parityMode   = m;
      extraStopBit = s;
      clockDivisor = dv;
   endtask

   task automatic one_frame(input string tag, input logic [7:0] d);
      put_byte(d);
      wait_start({tag, "_lat"}, 1);
      check_frame(tag, d);
      @(negedge clk);
      chk({tag, "_busy_end"}, int'(busy), 0);
      chk({tag, "_idle_tx"}, int'(tx), 1);
   endtask

   initial begin
      int low;
      int high;
      logic [7:0] d;
      rst           = 1'b0;
      breakReq      = 1'b0;
      bus.dataIn    = 8'h00;
      bus.dataValid = 1'b0;
      set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 16'd3);
      #12;
      chk("rst_tx", int'(tx), 1);
      chk("rst_ready", int'(bus.ready), 1);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1, 4-cycle bits
      one_frame("8n1_55", 8'h55);

      // 7E2, top bit ignored
      set_cfg(2'd2, 1'b1, 2'b10, 1'b1, 16'd3);
      one_frame("7e2_c3", 8'hC3);

      // 5-bit parity modes
      set_cfg(2'd0, 1'b1, 2'b01, 1'b0, 16'd2);
      one_frame("5o1_00", 8'h00);
      parityMode = 2'b11;
      one_frame("5m1_00", 8'h00);
      parityMode = 2'b00;
      one_frame("5s1_e0", 8'hE0);

      // back-to-back with valid held
      set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 16'd3);
      fork
         begin
            put_byte(8'hA5);
            put_byte(8'h3C);
         end
         begin
            wait_start("b2b_lat", 2);
            check_frame("b2b_a5", 8'hA5);
            chk("b2b_rdy_wait", int'(bus.ready), 0);
            @(negedge clk);
            check_frame("b2b_3c", 8'h3C);
            @(negedge clk);
            chk("b2b_busy_end", int'(busy), 0);
         end
      join

      // break straddling the end of a 100-cycle frame
      set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 16'd9);
      put_byte(8'h96);
      wait_start("brk_lat", 1);
      fork
         begin
            repeat (70) @(negedge clk);
            breakReq = 1'b1;
            put_byte(8'h4B);
            repeat (49) @(negedge clk);
            breakReq = 1'b0;
         end
         begin
            check_frame("brk_96", 8'h96);
            low = 0;
            for (int k = 0; k < 500; k++) begin
               @(negedge clk);
               if (tx !== 1'b0) break;
               low++;
            end
            chk("brk_low", low, 70 + 50 - 100 + 1);
            chk("brk_rdy", int'(bus.ready), 0);
            high = 1;
            for (int k = 0; k < 500; k++) begin
               @(negedge clk);
               if (tx !== 1'b1) break;
               high++;
            end
            chk("brk_high", high, 10);
            check_frame("brk_4b", 8'h4B);
            @(negedge clk);
            chk("brk_busy_end", int'(busy), 0);
         end
      join

      // async reset in the middle of data bits
      set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 16'd3);
      put_byte(8'h00);
      wait_start("rst_lat", 1);
      repeat (8) @(negedge clk);
      chk("mid_tx_low", int'(tx), 0);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_tx", int'(tx), 1);
      chk("mid_rst_ready", int'(bus.ready), 1);
      chk("mid_rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      one_frame("post_rst_5a", 8'h5A);

      // random frames
      for (int r = 0; r < 12; r++) begin
         set_cfg(2'($urandom_range(3)), 1'($urandom_range(1)),
                 2'($urandom_range(3)), 1'($urandom_range(1)),
                 16'($urandom_range(4)));
         d = 8'($urandom);
         one_frame($sformatf("rnd%0d", r), d);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
